subleq_exec_ctrl: RTL and testbench

- Consumer of the `E`/`F` phase strobes produced by `sequencer`.
- Runs one SUBLEQ instruction per pass through its micro-state machine: fetch A, B, C; read mem[A] and mem[B]; write mem[B] = mem[B] - mem[A]; branch to C if the result is <= 0, else PC+3.
- Sits between the sequencer and the single-port unified memory. It is the control core of the SUBLEQ machine.

---
 rtl/subleq_exec_ctrl.sv | 119 +++++++++++
 tb/tb_subleq_exec_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_exec_ctrl.sv
// SUBLEQ execution control core: steps one instruction through fetch, operand
// read and writeback micro-states, paced by the sequencer's E/F strobes.
module subleq_exec_ctrl #(
  parameter int unsigned   AW        = 8,
  parameter int unsigned   DW        = 8,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter logic [AW-1:0] HALT_ADDR = '1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          E,
  input  logic          F,
  output logic [AW-1:0] MEM_ADDR,
  input  logic [DW-1:0] MEM_RDATA,
  output logic [DW-1:0] MEM_WDATA,
  output logic          MEM_WE,
  output logic [AW-1:0] PC,
  output logic          HALTED,
  output logic [2:0]    STATE
);

  typedef enum logic [2:0] {
    S_FA   = 3'd0,
    S_FB   = 3'd1,
    S_FC   = 3'd2,
    S_RA   = 3'd3,
    S_RB   = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t        state;
  logic [AW-1:0] reg_a;
  logic [AW-1:0] reg_b;
  logic [AW-1:0] reg_c;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] res;
  logic          taken;

  // Wrapped difference; branch on zero or sign bit of the wrapped value
  assign res       = op_b - op_a;
  assign taken     = (res == '0) || res[DW-1];
  assign MEM_WDATA = res;
  assign STATE     = state;

  // Address mux and write enable; reset suppresses any in-flight write
  always_comb begin
    MEM_ADDR = PC;
    MEM_WE   = 1'b0;
    if (RST) begin
      MEM_ADDR = RESET_PC;
    end else begin
      case (state)
        S_FB: MEM_ADDR = PC + AW'(1);
        S_FC: MEM_ADDR = PC + AW'(2);
        S_RA: MEM_ADDR = reg_a;
        S_RB: MEM_ADDR = reg_b;
        S_WB: begin
          MEM_ADDR = reg_b;
          MEM_WE   = F;
        end
        default: MEM_ADDR = PC;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_FA;
      PC     <= RESET_PC;
      reg_a  <= '0;
      reg_b  <= '0;
      reg_c  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      HALTED <= 1'b0;
    end else begin
      case (state)
        S_FA: if (E) begin
          reg_a <= MEM_RDATA[AW-1:0];
          state <= S_FB;
        end
        S_FB: if (E) begin
          reg_b <= MEM_RDATA[AW-1:0];
          state <= S_FC;
        end
        S_FC: if (E) begin
          reg_c <= MEM_RDATA[AW-1:0];
          state <= S_RA;
        end
        S_RA: if (E) begin
          op_a  <= MEM_RDATA;
          state <= S_RB;
        end
        S_RB: if (E) begin
          op_b  <= MEM_RDATA;
          state <= S_WB;
        end
        S_WB: if (F) begin
          if (taken) begin
            PC <= reg_c;
            if (reg_c == HALT_ADDR) begin
              state  <= S_HALT;
              HALTED <= 1'b1;
            end else begin
              state <= S_FA;
            end
          end else begin
            PC    <= PC + AW'(3);
            state <= S_FA;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_subleq_exec_ctrl.sv
// Directed bench for subleq_exec_ctrl: two instances (RESET_PC 0 and 254)
// each backed by a 256-word asynchronous-read memory model.
module tb_subleq_exec_ctrl;

  logic       clk;
  logic       RST;
  logic       e0, f0, e1, f1;
  logic [7:0] addr0, rdata0, wdata0, pc0, addr1, rdata1, wdata1, pc1;
  logic       we0, halted0, we1, halted1;
  logic [2:0] state0, state1;

  logic [7:0] mem0 [0:255];
  logic [7:0] mem1 [0:255];
  int         wr0, wr1;
  int         n_tests, n_fail;
  int         base;

  subleq_exec_ctrl dut0 (
    .CLK(clk), .RST(RST), .E(e0), .F(f0),
    .MEM_ADDR(addr0), .MEM_RDATA(rdata0), .MEM_WDATA(wdata0), .MEM_WE(we0),
    .PC(pc0), .HALTED(halted0), .STATE(state0)
  );

  subleq_exec_ctrl #(.RESET_PC(8'd254)) dut1 (
    .CLK(clk), .RST(RST), .E(e1), .F(f1),
    .MEM_ADDR(addr1), .MEM_RDATA(rdata1), .MEM_WDATA(wdata1), .MEM_WE(we1),
    .PC(pc1), .HALTED(halted1), .STATE(state1)
  );

  assign rdata0 = mem0[addr0];
  assign rdata1 = mem1[addr1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic mem_proc();
    forever begin
      @(posedge clk);
      if (we0) begin mem0[addr0] = wdata0; wr0++; end
      if (we1) begin mem1[addr1] = wdata1; wr1++; end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b1;
    e0 = 1'b0; f0 = 1'b0; e1 = 1'b0; f1 = 1'b0;
    @(negedge clk);
    RST = 1'b0;
  endtask

  task automatic run_ef0(input int n);
    e0 = 1'b1; f0 = 1'b1;
    repeat (n) @(negedge clk);
    e0 = 1'b0; f0 = 1'b0;
  endtask

  task automatic step1();
    e1 = 1'b1;
    @(negedge clk);
    e1 = 1'b0;
  endtask

  task automatic load_basic(input logic [7:0] ma, input logic [7:0] mb);
    clear_mem();
    mem0[0] = 8'd10; mem0[1] = 8'd11; mem0[2] = 8'd6;
    mem0[10] = ma;   mem0[11] = mb;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    e0 = 1'b1; f0 = 1'b1; e1 = 1'b0; f1 = 1'b0;
    @(negedge clk);
    n_tests++; if (state0 !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state0); end
    n_tests++; if (pc0 !== 8'd0) begin n_fail++; $display("FAIL reset_pc got %0d exp 0", pc0); end
    n_tests++; if (halted0 !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted0); end
    n_tests++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", we0); end
    n_tests++; if (addr0 !== 8'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", addr0); end
    n_tests++; if (pc1 !== 8'd254) begin n_fail++; $display("FAIL reset_pc1 got %0d exp 254", pc1); end
    n_tests++; if (addr1 !== 8'd254) begin n_fail++; $display("FAIL reset_addr1 got %0d exp 254", addr1); end
    e0 = 1'b0; f0 = 1'b0;
    RST = 1'b0;
  endtask

  task automatic test_not_taken();
    load_basic(8'd3, 8'd5);
    do_reset();
    base = wr0;
    run_ef0(6);
    n_tests++; if (mem0[11] !== 8'd2) begin n_fail++; $display("FAIL nt_mem got %0d exp 2", mem0[11]); end
    n_tests++; if (wr0 - base !== 1) begin n_fail++; $display("FAIL nt_writes got %0d exp 1", wr0 - base); end
    n_tests++; if (pc0 !== 8'd3) begin n_fail++; $display("FAIL nt_pc got %0d exp 3", pc0); end
    n_tests++; if (state0 !== 3'd0) begin n_fail++; $display("FAIL nt_state got %0d exp 0", state0); end
  endtask

  task automatic test_taken();
    load_basic(8'd5, 8'd5);
    do_reset();
    base = wr0;
    run_ef0(6);
    n_tests++; if (mem0[11] !== 8'd0) begin n_fail++; $display("FAIL tk_mem got %0d exp 0", mem0[11]); end
    n_tests++; if (wr0 - base !== 1) begin n_fail++; $display("FAIL tk_writes got %0d exp 1", wr0 - base); end
    n_tests++; if (pc0 !== 8'd6) begin n_fail++; $display("FAIL tk_pc got %0d exp 6", pc0); end
    n_tests++; if (halted0 !== 1'b0) begin n_fail++; $display("FAIL tk_halted got %b exp 0", halted0); end
  endtask

  task automatic test_halt();
    clear_mem();
    mem0[0] = 8'd10; mem0[1] = 8'd10; mem0[2] = 8'd255; mem0[10] = 8'd7;
    do_reset();
    base = wr0;
    run_ef0(6);
    n_tests++; if (mem0[10] !== 8'd0) begin n_fail++; $display("FAIL halt_mem got %0d exp 0", mem0[10]); end
    n_tests++; if (pc0 !== 8'd255) begin n_fail++; $display("FAIL halt_pc got %0d exp 255", pc0); end
    n_tests++; if (halted0 !== 1'b1) begin n_fail++; $display("FAIL halt_flag got %b exp 1", halted0); end
    n_tests++; if (state0 !== 3'd6) begin n_fail++; $display("FAIL halt_state got %0d exp 6", state0); end
    run_ef0(20);
    n_tests++; if (wr0 - base !== 1) begin n_fail++; $display("FAIL halt_writes got %0d exp 1", wr0 - base); end
    n_tests++; if (state0 !== 3'd6) begin n_fail++; $display("FAIL halt_hold got %0d exp 6", state0); end
    n_tests++; if (pc0 !== 8'd255) begin n_fail++; $display("FAIL halt_pc_hold got %0d exp 255", pc0); end
    n_tests++; if (mem0[10] !== 8'd0) begin n_fail++; $display("FAIL halt_mem_hold got %0d exp 0", mem0[10]); end
  endtask

  task automatic test_wrap_overflow();
    clear_mem();
    mem1[254] = 8'h20; mem1[255] = 8'h21; mem1[0] = 8'h40;
    mem1[8'h20] = 8'hFF; mem1[8'h21] = 8'h7F;
    do_reset();
    base = wr1;
    n_tests++; if (addr1 !== 8'd254) begin n_fail++; $display("FAIL wrap_fa got %0d exp 254", addr1); end
    step1();
    n_tests++; if (addr1 !== 8'd255) begin n_fail++; $display("FAIL wrap_fb got %0d exp 255", addr1); end
    step1();
    n_tests++; if (addr1 !== 8'd0) begin n_fail++; $display("FAIL wrap_fc got %0d exp 0", addr1); end
    step1();
    n_tests++; if (addr1 !== 8'h20) begin n_fail++; $display("FAIL wrap_ra got %0d exp 32", addr1); end
    step1();
    n_tests++; if (addr1 !== 8'h21) begin n_fail++; $display("FAIL wrap_rb got %0d exp 33", addr1); end
    step1();
    n_tests++; if (state1 !== 3'd5) begin n_fail++; $display("FAIL wrap_state got %0d exp 5", state1); end
    n_tests++; if (wdata1 !== 8'h80) begin n_fail++; $display("FAIL ovf_wdata got %0h exp 80", wdata1); end
    n_tests++; if (we1 !== 1'b0) begin n_fail++; $display("FAIL ovf_we_noF got %b exp 0", we1); end
    f1 = 1'b1;
    #1;
    n_tests++; if (we1 !== 1'b1) begin n_fail++; $display("FAIL ovf_we got %b exp 1", we1); end
    @(negedge clk);
    f1 = 1'b0;
    n_tests++; if (pc1 !== 8'h40) begin n_fail++; $display("FAIL ovf_pc got %0h exp 40", pc1); end
    n_tests++; if (mem1[8'h21] !== 8'h80) begin n_fail++; $display("FAIL ovf_mem got %0h exp 80", mem1[8'h21]); end
    n_tests++; if (wr1 - base !== 1) begin n_fail++; $display("FAIL ovf_writes got %0d exp 1", wr1 - base); end
  endtask

  task automatic test_gating();
    load_basic(8'd3, 8'd5);
    do_reset();
    base = wr0;
    for (int s = 0; s < 5; s++) begin
      e0 = 1'b0; f0 = 1'b1;
      #1;
      n_tests++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL gate_we s%0d got %b exp 0", s, we0); end
      @(negedge clk);
      n_tests++; if (state0 !== 3'(s)) begin n_fail++; $display("FAIL gate_f_hold got %0d exp %0d", state0, s); end
      f0 = 1'b0;
      if (s == 3) begin
        repeat (5) @(negedge clk);
        n_tests++; if (state0 !== 3'd3) begin n_fail++; $display("FAIL gate_e_low got %0d exp 3", state0); end
      end
      if (s < 4) step_e0();
    end
    e0 = 1'b1; f0 = 1'b1;
    @(negedge clk);
    e0 = 1'b0; f0 = 1'b0;
    n_tests++; if (state0 !== 3'd5) begin n_fail++; $display("FAIL gate_ef_one got %0d exp 5", state0); end
    n_tests++; if (wr0 - base !== 0) begin n_fail++; $display("FAIL gate_nowrite got %0d exp 0", wr0 - base); end
    repeat (3) @(negedge clk);
    n_tests++; if (state0 !== 3'd5) begin n_fail++; $display("FAIL gate_wb_hold got %0d exp 5", state0); end
    f0 = 1'b1;
    @(negedge clk);
    f0 = 1'b0;
    n_tests++; if (mem0[11] !== 8'd2) begin n_fail++; $display("FAIL gate_mem got %0d exp 2", mem0[11]); end
    n_tests++; if (pc0 !== 8'd3) begin n_fail++; $display("FAIL gate_pc got %0d exp 3", pc0); end
    n_tests++; if (wr0 - base !== 1) begin n_fail++; $display("FAIL gate_writes got %0d exp 1", wr0 - base); end
  endtask

  task automatic step_e0();
    e0 = 1'b1;
    @(negedge clk);
    e0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    load_basic(8'd3, 8'd5);
    do_reset();
    base = wr0;
    e0 = 1'b1;
    repeat (5) @(negedge clk);
    e0 = 1'b0;
    n_tests++; if (state0 !== 3'd5) begin n_fail++; $display("FAIL rm_state_wb got %0d exp 5", state0); end
    f0 = 1'b1;
    #1;
    n_tests++; if (we0 !== 1'b1) begin n_fail++; $display("FAIL rm_we_before got %b exp 1", we0); end
    #2;
    RST = 1'b1;
    #1;
    n_tests++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL rm_we_drop got %b exp 0", we0); end
    n_tests++; if (state0 !== 3'd0) begin n_fail++; $display("FAIL rm_state got %0d exp 0", state0); end
    n_tests++; if (pc0 !== 8'd0) begin n_fail++; $display("FAIL rm_pc got %0d exp 0", pc0); end
    @(negedge clk);
    n_tests++; if (mem0[11] !== 8'd5) begin n_fail++; $display("FAIL rm_mem got %0d exp 5", mem0[11]); end
    n_tests++; if (wr0 - base !== 0) begin n_fail++; $display("FAIL rm_writes got %0d exp 0", wr0 - base); end
    f0 = 1'b0;
    RST = 1'b0;
  endtask

  // Second instruction's A word is rewritten by the first instruction
  task automatic test_back_to_back();
    clear_mem();
    mem0[0] = 8'd20; mem0[1] = 8'd3;  mem0[2] = 8'd3;
    mem0[3] = 8'd7;  mem0[4] = 8'd21; mem0[5] = 8'd9;
    mem0[20] = 8'd2; mem0[21] = 8'd10;
    do_reset();
    base = wr0;
    run_ef0(12);
    n_tests++; if (mem0[3] !== 8'd5) begin n_fail++; $display("FAIL b2b_mem3 got %0d exp 5", mem0[3]); end
    n_tests++; if (mem0[21] !== 8'd1) begin n_fail++; $display("FAIL b2b_mem21 got %0d exp 1", mem0[21]); end
    n_tests++; if (pc0 !== 8'd6) begin n_fail++; $display("FAIL b2b_pc got %0d exp 6", pc0); end
    n_tests++; if (wr0 - base !== 2) begin n_fail++; $display("FAIL b2b_writes got %0d exp 2", wr0 - base); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; wr0 = 0; wr1 = 0; base = 0;
    RST = 1'b1;
    e0 = 1'b0; f0 = 1'b0; e1 = 1'b0; f1 = 1'b0;
    clear_mem();
    fork mem_proc(); join_none
    test_reset();
    test_not_taken();
    test_taken();
    test_halt();
    test_wrap_overflow();
    test_gating();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
